// File: rtl/cv32e40p_ft_pkg.sv
// Shared definitions for the permanent-fault tracker.
// Holds the per-unit health state encoding, the counter type and the
// default sizing constants used by the tracker top and its per-unit FSM.
package cv32e40p_ft_pkg;

  localparam int unsigned FT_N_ALU_DEF        = 4;
  localparam int unsigned FT_N_MULT_DEF       = 3;
  localparam int unsigned FT_THRESHOLD_DEF    = 8;
  localparam int unsigned FT_DECAY_PERIOD_DEF = 256;

  // 4 bits covers the full THRESHOLD range (2..15)
  localparam int unsigned FT_CNT_W = 4;

  typedef logic [FT_CNT_W-1:0] err_cnt_t;

  typedef enum logic [1:0] {
    UNIT_HEALTHY = 2'd0,
    UNIT_SUSPECT = 2'd1,
    UNIT_FAULTY  = 2'd2
  } unit_state_e;

endpackage

// File: rtl/cv32e40p_unit_fault_fsm_ft.sv
// Per-unit error accumulator and health FSM.
// Ports:
//   clk, rst_n    clock / synchronous active-low reset
//   clear         software clear back to HEALTHY with counter 0
//   err           sampled disagreement for this unit (already qualified by valid)
//   decay_tick    shared window wrap; decrements a SUSPECT unit with no error
//   faulty        registered faulty flag (state == FAULTY)
//   faulty_nxt    value faulty will take at the next edge (for edge detect)
module cv32e40p_unit_fault_fsm_ft
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned THRESHOLD = FT_THRESHOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic err,
  input  logic decay_tick,
  output logic faulty,
  output logic faulty_nxt
);

  localparam err_cnt_t THR = err_cnt_t'(THRESHOLD);

  unit_state_e state_q, state_d;
  err_cnt_t    cnt_q,   cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      UNIT_HEALTHY: begin
        if (err) begin
          state_d = UNIT_SUSPECT;
          cnt_d   = err_cnt_t'(1);
        end
      end
      UNIT_SUSPECT: begin
        // an error in the tick cycle wins over decay
        if (err) begin
          if (cnt_q >= THR - err_cnt_t'(1)) begin
            cnt_d   = THR;
            state_d = UNIT_FAULTY;
          end else begin
            cnt_d = cnt_q + err_cnt_t'(1);
          end
        end else if (decay_tick) begin
          if (cnt_q <= err_cnt_t'(1)) begin
            cnt_d   = '0;
            state_d = UNIT_HEALTHY;
          end else begin
            cnt_d = cnt_q - err_cnt_t'(1);
          end
        end
      end
      UNIT_FAULTY: begin
        // sticky: counter frozen at THRESHOLD until clear/reset
        cnt_d = THR;
      end
      default: begin
        state_d = UNIT_HEALTHY;
        cnt_d   = '0;
      end
    endcase
    if (clear) begin
      state_d = UNIT_HEALTHY;
      cnt_d   = '0;
    end
  end

  assign faulty_nxt = (state_d == UNIT_FAULTY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNIT_HEALTHY;
      cnt_q   <= '0;
      faulty  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      faulty  <= faulty_nxt;
    end
  end

endmodule

// File: rtl/cv32e40p_perm_fault_tracker_ft.sv
// Permanent-fault tracker for the replicated ALU/MULT datapaths.
// Every voting event reports which replicas disagreed with the majority;
// each replica accumulates errors in its own counter, errors decay once
// per DECAY_PERIOD window, and a replica reaching THRESHOLD is latched
// faulty until software clear or reset.
// Ports:
//   clk, rst_n                 clock / synchronous active-low reset
//   alu_err_valid_i, alu_err_i ALU vote event and per-ALU disagreement
//   mult_err_valid_i, mult_err_i MULT vote event and per-MULT disagreement
//   clear_i                    clear all tracking state (beats errors)
//   permanent_faulty_alu_o     registered faulty flag per ALU
//   permanent_faulty_mult_o    registered faulty flag per MULT
//   fault_irq_o                one-cycle pulse when any flag newly sets
module cv32e40p_perm_fault_tracker_ft
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned N_ALU        = FT_N_ALU_DEF,
  parameter int unsigned N_MULT       = FT_N_MULT_DEF,
  parameter int unsigned THRESHOLD    = FT_THRESHOLD_DEF,
  parameter int unsigned DECAY_PERIOD = FT_DECAY_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_err_valid_i,
  input  logic [N_ALU-1:0]  alu_err_i,
  input  logic              mult_err_valid_i,
  input  logic [N_MULT-1:0] mult_err_i,
  input  logic              clear_i,
  output logic [N_ALU-1:0]  permanent_faulty_alu_o,
  output logic [N_MULT-1:0] permanent_faulty_mult_o,
  output logic              fault_irq_o
);

  localparam int unsigned WIN_W   = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
  localparam int unsigned N_UNITS = N_ALU + N_MULT;

  // window counter: all-ones is the last cycle of the window = decay tick
  logic [WIN_W-1:0] win_q;
  logic             decay_tick;

  assign decay_tick = &win_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) win_q <= '0;
    else                   win_q <= win_q + WIN_W'(1);
  end

  // units 0..N_ALU-1 are ALUs, the rest MULTs
  logic [N_UNITS-1:0] unit_err;
  logic [N_UNITS-1:0] flags_q, flags_d;

  assign unit_err = {({N_MULT{mult_err_valid_i}} & mult_err_i),
                     ({N_ALU{alu_err_valid_i}}  & alu_err_i)};

  for (genvar u = 0; u < N_UNITS; u++) begin : g_unit
    cv32e40p_unit_fault_fsm_ft #(
      .THRESHOLD (THRESHOLD)
    ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear_i),
      .err        (unit_err[u]),
      .decay_tick (decay_tick),
      .faulty     (flags_q[u]),
      .faulty_nxt (flags_d[u])
    );
  end

  assign permanent_faulty_alu_o  = flags_q[N_ALU-1:0];
  assign permanent_faulty_mult_o = flags_q[N_UNITS-1:N_ALU];

  // registered so the pulse lines up with the cycle the new flag appears
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) fault_irq_o <= 1'b0;
    else                   fault_irq_o <= |(flags_d & ~flags_q);
  end

endmodule

// File: doc/cv32e40p_perm_fault_tracker_ft.md
CV32E40P_PERM_FAULT_TRACKER_FT -- requirements
Module: cv32e40p_perm_fault_tracker_ft

Interface
REQ-001 Parameter N_ALU, default 4: number of replicated ALUs tracked.
REQ-002 Parameter N_MULT, default 3: number of replicated MULTs tracked.
REQ-003 Parameter THRESHOLD, default 8: error count that declares a unit permanently faulty (range 2..15).
REQ-004 Parameter DECAY_PERIOD, default 256: cycles per decay tick (power of two, 2..65536).
REQ-005 clk  input  1  clock, rising-edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 alu_err_valid_i  input  1  ALU vote event this cycle.
REQ-008 alu_err_i  input  N_ALU  per-ALU disagreement with majority; sampled only when alu_err_valid_i=1.
REQ-009 mult_err_valid_i  input  1  MULT vote event this cycle.
REQ-010 mult_err_i  input  N_MULT  per-MULT disagreement; sampled only when mult_err_valid_i=1.
REQ-011 clear_i  input  1  software clear of all tracking state.
REQ-012 permanent_faulty_alu_o  output  N_ALU  registered faulty flags, one per ALU, feeding the dispatcher.
REQ-013 permanent_faulty_mult_o  output  N_MULT  registered faulty flags, one per MULT.
REQ-014 fault_irq_o  output  1  one-cycle pulse when any faulty flag newly sets.

Function
REQ-015 Each unit SHALL own a 4-bit saturating error counter and a state HEALTHY/SUSPECT/FAULTY.
REQ-016 HEALTHY->SUSPECT on a sampled error for that unit; counter becomes 1.
REQ-017 SUSPECT: sampled error increments counter; when counter reaches THRESHOLD, state->FAULTY in the same register update.
REQ-018 SUSPECT->HEALTHY when a decay tick brings the counter to 0.
REQ-019 FAULTY is sticky; errors and decay ticks SHALL be ignored; counter frozen at THRESHOLD.
REQ-020 Faulty flag output = (state==FAULTY), registered; asserted the cycle after the error edge that completes THRESHOLD (latency 1).
REQ-021 A free-running window counter (log2(DECAY_PERIOD) bits) SHALL wrap every DECAY_PERIOD cycles; the wrap cycle is the decay tick.
REQ-022 On decay tick each SUSPECT unit with no sampled error that cycle decrements by 1; a unit with a sampled error that cycle increments and skips decay.
REQ-023 Multiple err bits in one event SHALL each update their own unit independently; ALU and MULT events in the same cycle both apply.
REQ-024 err bits with valid=0 SHALL have no effect.
REQ-025 fault_irq_o = 1 for exactly one cycle when the OR-reduction of (new flags & ~old flags) across both vectors is non-zero; simultaneous new faults yield one pulse.
REQ-026 clear_i=1 SHALL return all units to HEALTHY, counters and window counter to 0, flags and fault_irq_o to 0 next cycle; clear_i has priority over same-cycle errors.
REQ-027 Counters SHALL never exceed THRESHOLD nor wrap below 0.

Reset
REQ-028 rst_n=0 at a clock edge SHALL set all states HEALTHY, all counters 0, window counter 0, all outputs 0, overriding clear_i and errors.
REQ-029 Reset mid-accumulation SHALL discard all partial counts; no fault_irq_o pulse on reset release.

Structure
REQ-030 Shared package cv32e40p_ft_pkg SHALL hold the unit-state enum and default THRESHOLD/DECAY_PERIOD/N_ALU/N_MULT constants.
REQ-031 Per-unit counter+FSM SHALL be sub-module cv32e40p_unit_fault_fsm_ft, instantiated N_ALU+N_MULT times; window counter and irq logic in the top.

Verification
REQ-032 Reset: hold rst_n=0 with alu_err_i=4'b1111 valid -> all outputs 0; release -> still 0.
REQ-033 Eight consecutive valid events alu_err_i=4'b0100 -> permanent_faulty_alu_o=4'b0100 one cycle after 8th event, fault_irq_o high exactly that cycle; further errors on ALU2 -> no further pulse.
REQ-034 Seven ALU1 errors, then 1792 idle cycles -> ALU1 HEALTHY (counter 0); seven more errors -> flags remain 4'b0000.
REQ-035 ALU0 counter 7 and error event on the decay-tick cycle -> counter 8, FAULTY; MULT1 at 3 on same tick without error -> 2.
REQ-036 Same-cycle mult_err_i=3'b101 reaching threshold on units 0 and 2 -> permanent_faulty_mult_o=3'b101, single one-cycle irq pulse.
REQ-037 clear_i=1 with alu_err_i=4'b1111 valid while flags=4'b0110 -> next cycle all flags 0, counters 0, no irq.
